// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and load sanitising helper for the scan counter.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Non-decimal nibbles collapse to zero so the counter never holds an illegal digit.
  function automatic bcd_t bcd_sanitize(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MIN : v;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_digit.sv
// One BCD digit cell: parallel load, up/down step, and terminal-value flag
// used by the parent to build the ripple-free carry chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  bcd_t load_val,
  input  logic step,
  input  logic up,
  output bcd_t value,
  output logic term
);

  bcd_t value_q;
  bcd_t value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = bcd_sanitize(load_val);
    end else if (step) begin
      if (up) begin
        value_d = (value_q == BCD_MAX) ? BCD_MIN : value_q + 4'd1;
      end else begin
        value_d = (value_q == BCD_MIN) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= BCD_MIN;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign term  = up ? (value_q == BCD_MAX) : (value_q == BCD_MIN);

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with time-multiplexed digit scan output.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    carry,
  output logic [BCD_W-1:0]        digit_bcd,
  output logic [DIGITS-1:0]       digit_sel
);

  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_t              digit_val [DIGITS];
  logic [DIGITS-1:0] term;
  logic [DIGITS:0]   low_term;

  assign low_term[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val[gi*BCD_W +: BCD_W]),
        .step     (en & low_term[gi]),
        .up       (up),
        .value    (digit_val[gi]),
        .term     (term[gi])
      );
      assign low_term[gi+1]             = low_term[gi] & term[gi];
      assign count[gi*BCD_W +: BCD_W]   = digit_val[gi];
    end
  endgenerate

`ifdef BCD_SCAN_LZB_EN
  // hz[i]: digit i and everything above it is zero; digit 0 is forced visible.
  logic [DIGITS:0] hz;
  assign hz[DIGITS] = 1'b1;
  assign hz[0]      = 1'b0;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_hz
      assign hz[gi] = hz[gi+1] & (digit_val[gi] == BCD_MIN);
    end
  endgenerate
`endif

  logic [PRE_W-1:0]  pre_q,   pre_d;
  logic [SLOT_W-1:0] slot_q,  slot_d;
  logic [DIGITS-1:0] sel_q,   sel_d;
  bcd_t              bcd_q,   bcd_d;
  logic              carry_q, carry_d;

  always_comb begin
    pre_d  = pre_q + 1'b1;
    slot_d = slot_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d  = '0;
      slot_d = (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + 1'b1;
    end

    sel_d = '0;
    bcd_d = BCD_MIN;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
`ifdef BCD_SCAN_LZB_EN
        if (!hz[i]) begin
          sel_d[i] = 1'b1;
          bcd_d    = digit_val[i];
        end
`else
        sel_d[i] = 1'b1;
        bcd_d    = digit_val[i];
`endif
      end
    end

    // A step with every digit terminal is exactly the wrap/borrow event.
    carry_d = en & ~load & low_term[DIGITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      slot_q  <= '0;
      sel_q   <= DIGITS'(1);
      bcd_q   <= BCD_MIN;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      slot_q  <= slot_d;
      sel_q   <= sel_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
    end
  end

  assign carry     = carry_q;
  assign digit_bcd = bcd_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4); honours BCD_SCAN_LZB_EN.
module tb_bcd_scan_counter;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  digit_bcd;
  logic [3:0]  digit_sel;

  bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .carry     (carry),
    .digit_bcd (digit_bcd),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    bit          scan;
    logic [15:0] cnt;
    logic        cy;
    logic [3:0]  sel;
    logic [3:0]  bcd;
    int          id;
  } exp_t;

  typedef struct packed {
    logic        en;
    logic        up;
    logic        ld;
    logic [15:0] lv;
    logic [15:0] cnt;
    logic        cy;
  } vec_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rst_cyc  = 0;
  bit   drain_req  = 1'b0;
  bit   drain_done = 1'b0;

  function automatic void push_count(input int t, input logic [15:0] cnt, input logic cy, input int id);
    exp_t e;
    e.t = t; e.scan = 1'b0; e.cnt = cnt; e.cy = cy; e.sel = 4'h0; e.bcd = 4'h0; e.id = id;
    q.push_back(e);
  endfunction

  // Expected scan output after edge t, given the count held after edge t-1.
  function automatic void push_scan(input int t, input logic [15:0] cnt, input int id);
    exp_t e;
    int slot;
    slot = (t <= rst_cyc) ? 0 : ((t - 1 - rst_cyc) / SCAN_DIV) % DIGITS;
    e.t = t; e.scan = 1'b1; e.cnt = 16'h0; e.cy = 1'b0; e.id = id;
    e.sel = 4'b0001 << slot;
    e.bcd = cnt[slot*4 +: 4];
`ifdef BCD_SCAN_LZB_EN
    if (slot != 0 && (cnt >> (slot * 4)) == 16'h0) begin
      e.sel = 4'b0000;
      e.bcd = 4'h0;
    end
`endif
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].t < cyc) begin
        checks++; failures++;
        $display("FAIL stale id=%0d due=%0d now=%0d", q[i].id, q[i].t, cyc);
        q.delete(i);
      end else if (q[i].t == cyc) begin
        checks += 2;
        if (q[i].scan) begin
          if (digit_sel !== q[i].sel) begin
            failures++;
            $display("FAIL sel id=%0d cyc=%0d got=%b exp=%b", q[i].id, cyc, digit_sel, q[i].sel);
          end
          if (digit_bcd !== q[i].bcd) begin
            failures++;
            $display("FAIL bcd id=%0d cyc=%0d got=%h exp=%h", q[i].id, cyc, digit_bcd, q[i].bcd);
          end
          $display("scan  id=%0d cyc=%0d sel=%b bcd=%h", q[i].id, cyc, digit_sel, digit_bcd);
        end else begin
          if (count !== q[i].cnt) begin
            failures++;
            $display("FAIL count id=%0d cyc=%0d got=%h exp=%h", q[i].id, cyc, count, q[i].cnt);
          end
          if (carry !== q[i].cy) begin
            failures++;
            $display("FAIL carry id=%0d cyc=%0d got=%b exp=%b", q[i].id, cyc, carry, q[i].cy);
          end
          $display("count id=%0d cyc=%0d count=%h carry=%b", q[i].id, cyc, count, carry);
        end
        q.delete(i);
      end
    end
    if (drain_req && !drain_done) begin
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL drain leftover=%0d exp=0", q.size());
      end
      drain_done = 1'b1;
    end
  end

  task automatic apply(input vec_t v, input int id);
    @(posedge clk); #2;
    rst = 1'b0; en = v.en; up = v.up; load = v.ld; load_val = v.lv;
    push_count(cyc + 1, v.cnt, v.cy, id);
    push_scan(cyc + 2, v.cnt, id);
  endtask

  task automatic idle(input logic [15:0] cnt, input int id);
    vec_t v;
    v = '{en: 1'b0, up: 1'b0, ld: 1'b0, lv: 16'h0, cnt: cnt, cy: 1'b0};
    apply(v, id);
  endtask

  // Reset with conflicting load/en asserted; they must be discarded.
  task automatic do_reset(input int id);
    exp_t e;
    @(posedge clk); #2;
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h9999;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].t == cyc + 1) q.delete(i);
    end
    push_count(cyc + 1, 16'h0, 1'b0, id);
    e.t = cyc + 1; e.scan = 1'b1; e.cnt = 16'h0; e.cy = 1'b0;
    e.sel = 4'b0001; e.bcd = 4'h0; e.id = id;
    q.push_back(e);
    rst_cyc = cyc + 1;
  endtask

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    vecs = '{
      '{1'b0, 1'b0, 1'b1, 16'h0999, 16'h0999, 1'b0},
      '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0},
      '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0},
      '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h3A7F, 16'h3070, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h3069, 1'b0},
      '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h3070, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0},
      '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h0998, 16'h0998, 1'b0},
      '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0999, 1'b0},
      '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0999, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0998, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h4321, 16'h4321, 1'b0}
    };

    do_reset(900);
    do_reset(901);
    repeat (5) idle(16'h0000, 902);
    for (int i = 0; i < NV; i++) apply(vecs[i], i);
    repeat (18) idle(16'h4321, 100);

    // Park mid-slot away from slot 0 so the reset visibly returns the scan to digit 0.
    for (int k = 0; k < 32 && ((cyc - rst_cyc) % 16) != 6; k++) idle(16'h4321, 101);
    do_reset(102);

    apply('{1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0}, 200);
    repeat (18) idle(16'h0005, 201);
    apply('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0}, 300);
    repeat (18) idle(16'h0000, 301);

    repeat (4) @(posedge clk);
    drain_req = 1'b1;
    wait (drain_done);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit=20000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
